// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM states, access widths,
// byte counts and the codebase's common constants.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    localparam logic [2:0] BYTES_B = 3'd1;
    localparam logic [2:0] BYTES_H = 3'd2;
    localparam logic [2:0] BYTES_W = 3'd4;

    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Both 2'b10 and 2'b11 select a full word.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            WIDTH_B: return BYTES_B;
            WIDTH_H: return BYTES_H;
            default: return BYTES_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller arbitrating icache refills against
// MEM-stage loads/stores (MEM has priority); all outputs are registered.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_cancel,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    output logic                  icache_we,
    output logic [ADDR_WIDTH-1:0] icache_waddr,
    output logic [31:0]           icache_winst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [1:0]            mem_width,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  busy
);

    state_t                state, state_nx;
    logic [2:0]            cnt, cnt_nx;
    logic [2:0]            nbytes, nbytes_nx;
    logic [ADDR_WIDTH-1:0] base, base_nx;
    logic [31:0]           wdata_q, wdata_nx;
    logic [31:0]           asm_q, asm_nx;

    logic                  if_done_nx, mem_done_nx, ram_wr_nx;
    logic [31:0]           if_inst_nx, mem_rdata_nx;
    logic [ADDR_WIDTH-1:0] icache_waddr_nx, ram_a_nx;
    logic [7:0]            ram_dout_nx;
    logic [1:0]            rd_lane, wr_lane;

    // cnt is the byte index driven this cycle; the byte returning now is cnt-1.
    assign rd_lane = cnt[1:0] - 2'd1;
    assign wr_lane = cnt[1:0] + 2'd1;

    assign icache_we    = if_done;
    assign icache_winst = if_inst;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            nbytes       <= '0;
            base         <= '0;
            wdata_q      <= ZeroWord;
            asm_q        <= ZeroWord;
            if_done      <= Disable;
            if_inst      <= ZeroWord;
            icache_waddr <= '0;
            mem_done     <= Disable;
            mem_rdata    <= ZeroWord;
            ram_a        <= '0;
            ram_wr       <= Disable;
            ram_dout     <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            nbytes       <= nbytes_nx;
            base         <= base_nx;
            wdata_q      <= wdata_nx;
            asm_q        <= asm_nx;
            if_done      <= if_done_nx;
            if_inst      <= if_inst_nx;
            icache_waddr <= icache_waddr_nx;
            mem_done     <= mem_done_nx;
            mem_rdata    <= mem_rdata_nx;
            ram_a        <= ram_a_nx;
            ram_wr       <= ram_wr_nx;
            ram_dout     <= ram_dout_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        nbytes_nx       = nbytes;
        base_nx         = base;
        wdata_nx        = wdata_q;
        asm_nx          = asm_q;
        if_done_nx      = Disable;
        if_inst_nx      = if_inst;
        icache_waddr_nx = icache_waddr;
        mem_done_nx     = Disable;
        mem_rdata_nx    = mem_rdata;
        ram_a_nx        = '0;
        ram_wr_nx       = Disable;
        ram_dout_nx     = '0;

        case (state)
            IDLE: begin
                // No grant while a done pulse is out, so requesters can drop req.
                if (!if_done && !mem_done) begin
                    if (mem_req) begin
                        base_nx   = mem_addr;
                        nbytes_nx = width_bytes(mem_width);
                        wdata_nx  = mem_wdata;
                        asm_nx    = ZeroWord;
                        cnt_nx    = '0;
                        ram_a_nx  = mem_addr;
                        if (mem_we) begin
                            state_nx    = MEM_WR;
                            ram_wr_nx   = Enable;
                            ram_dout_nx = mem_wdata[7:0];
                        end else begin
                            state_nx = MEM_RD;
                        end
                    end else if (if_req && !if_cancel) begin
                        base_nx   = if_addr;
                        nbytes_nx = BYTES_W;
                        asm_nx    = ZeroWord;
                        cnt_nx    = '0;
                        ram_a_nx  = if_addr;
                        state_nx  = IF_RD;
                    end
                end
            end

            IF_RD, MEM_RD: begin
                if (state == IF_RD && if_cancel) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    if (cnt != 3'd0)
                        asm_nx[{rd_lane, 3'b000} +: 8] = ram_din;
                    if (cnt + 3'd1 < nbytes)
                        ram_a_nx = base + ADDR_WIDTH'(cnt + 3'd1);
                    if (cnt == nbytes) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        if (state == IF_RD) begin
                            if_done_nx      = Enable;
                            if_inst_nx      = asm_nx;
                            icache_waddr_nx = base;
                        end else begin
                            mem_done_nx  = Enable;
                            mem_rdata_nx = asm_nx;
                        end
                    end else begin
                        cnt_nx = cnt + 3'd1;
                    end
                end
            end

            MEM_WR: begin
                if (cnt + 3'd1 < nbytes) begin
                    cnt_nx      = cnt + 3'd1;
                    ram_a_nx    = base + ADDR_WIDTH'(cnt + 3'd1);
                    ram_wr_nx   = Enable;
                    ram_dout_nx = wdata_q[{wr_lane, 3'b000} +: 8];
                end else begin
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    mem_done_nx = Enable;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level byte-memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, if_done, icache_we;
    logic [31:0] if_addr, if_inst, icache_waddr, icache_winst;
    logic        mem_req, mem_we, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic [31:0] ram_a;
    logic        ram_wr, busy;
    logic [7:0]  ram_dout, ram_din;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_done(if_done), .if_inst(if_inst),
        .icache_we(icache_we), .icache_waddr(icache_waddr), .icache_winst(icache_winst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_width(mem_width), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy)
    );

    // Byte RAM with one cycle read latency.
    always @(posedge clk) begin
        ram_din <= ram_mem.exists(ram_a) ? ram_mem[ram_a] : 8'h00;
        if (ram_wr) ram_mem[ram_a] = ram_dout;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    endfunction

    function automatic int unsigned nb(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_if_done"},  32'(if_done), 0);
        check_eq({tag, "_if_inst"},  if_inst, 0);
        check_eq({tag, "_ic_we"},    32'(icache_we), 0);
        check_eq({tag, "_ic_waddr"}, icache_waddr, 0);
        check_eq({tag, "_ic_winst"}, icache_winst, 0);
        check_eq({tag, "_mem_done"}, 32'(mem_done), 0);
        check_eq({tag, "_rdata"},    mem_rdata, 0);
        check_eq({tag, "_ram_a"},    ram_a, 0);
        check_eq({tag, "_ram_wr"},   32'(ram_wr), 0);
        check_eq({tag, "_ram_dout"}, 32'(ram_dout), 0);
        check_eq({tag, "_busy"},     32'(busy), 0);
    endtask

    // Called at the negedge of grant cycle 0; returns one idle cycle after done.
    task automatic mem_run(input logic we, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] wd);
        int unsigned n;
        int unsigned last;
        logic [31:0] expd;
        n    = nb(w);
        last = we ? n + 1 : n + 2;
        expd = 0;
        for (int unsigned k = 0; k < n; k++)
            expd = expd | (32'(ref_rd(a + k)) << (8 * k));
        if (we)
            for (int unsigned k = 0; k < n; k++)
                ref_mem[a + k] = 8'(wd >> (8 * k));
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_width = w; mem_wdata = wd;
        for (int unsigned c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mem_addr = $urandom; mem_wdata = $urandom; mem_width = 2'($urandom_range(0, 3));
            end
            check_eq("mem_if_done_low", 32'(if_done), 0);
            if (c <= n) begin
                check_eq("mem_ram_a",    ram_a, a + c - 1);
                check_eq("mem_ram_wr",   32'(ram_wr), 32'(we));
                check_eq("mem_ram_dout", 32'(ram_dout), we ? 32'(8'(wd >> (8 * (c - 1)))) : 0);
                check_eq("mem_done_early", 32'(mem_done), 0);
                check_eq("mem_busy", 32'(busy), 1);
            end else if (c < last) begin
                check_eq("mem_gap_ram_a", ram_a, 0);
                check_eq("mem_done_early", 32'(mem_done), 0);
            end else begin
                check_eq("mem_done", 32'(mem_done), 1);
                check_eq("mem_end_ram_wr", 32'(ram_wr), 0);
                check_eq("mem_end_ram_a", ram_a, 0);
                check_eq("mem_end_busy", 32'(busy), 0);
                if (!we) check_eq("mem_rdata", mem_rdata, expd);
                mem_req = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("mem_done_pulse", 32'(mem_done), 0);
        if (!we) check_eq("mem_rdata_hold", mem_rdata, expd);
    endtask

    // cancel_at = 0: full fetch; 1..5: if_cancel raised in that cycle.
    task automatic if_run(input logic [31:0] a, input int unsigned cancel_at);
        logic [31:0] expi;
        int unsigned last;
        expi = {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
        last = (cancel_at == 0) ? 6 : cancel_at;
        if_req = 1'b1; if_addr = a; if_cancel = 1'b0;
        for (int unsigned c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) if_addr = $urandom & 32'hFFFF_FFFC;
            if (c <= 4) begin
                check_eq("if_ram_a", ram_a, a + c - 1);
                check_eq("if_ram_wr", 32'(ram_wr), 0);
            end else begin
                check_eq("if_gap_ram_a", ram_a, 0);
            end
            if (c < 6) begin
                check_eq("if_done_early", 32'(if_done), 0);
                check_eq("if_busy", 32'(busy), 1);
            end else begin
                check_eq("if_done", 32'(if_done), 1);
                check_eq("if_icache_we", 32'(icache_we), 1);
                check_eq("if_inst", if_inst, expi);
                check_eq("if_icache_winst", icache_winst, expi);
                check_eq("if_icache_waddr", icache_waddr, a);
                check_eq("if_end_busy", 32'(busy), 0);
                if_req = 1'b0;
            end
            if (c == cancel_at) if_cancel = 1'b1;
        end
        @(negedge clk);
        if (cancel_at == 0) begin
            check_eq("if_done_pulse", 32'(if_done), 0);
            check_eq("if_inst_hold", if_inst, expi);
        end else begin
            check_eq("cancel_busy", 32'(busy), 0);
            check_eq("cancel_ram_a", ram_a, 0);
            if_cancel = 1'b0;
            if_req = 1'b0;
            repeat (6) begin
                @(negedge clk);
                check_eq("cancel_no_done", 32'(if_done), 0);
                check_eq("cancel_no_icache_we", 32'(icache_we), 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_cancel = 0; if_addr = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_width = 0; mem_wdata = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        if_run(32'h100, 0);
        check_eq("plan_inst", if_inst, 32'h0000_0513);

        poke(32'h2003, 8'hF0); poke(32'h2004, 8'hAA); poke(32'h2002, 8'h55);
        mem_run(1'b0, 32'h2003, 2'b00, 32'h0);
        check_eq("plan_byte_load", mem_rdata, 32'h0000_00F0);

        mem_run(1'b1, 32'h3000, 2'b10, 32'hDEAD_BEEF);
        check_eq("plan_store_b3", 32'(ram_rd(32'h3003)), 32'hDE);

        // Simultaneous requests: half store first, IF granted after turnaround.
        if_req = 1'b1; if_addr = 32'h100;
        mem_run(1'b1, 32'h4000, 2'b01, 32'h1234_ABCD);
        if_run(32'h100, 0);

        poke(32'h500, 8'h01); poke(32'h501, 8'h02); poke(32'h502, 8'h03); poke(32'h503, 8'h04);
        if_run(32'h500, 3);
        if_run(32'h500, 5);

        // Reset in the middle of a word store: only byte 0 reaches RAM.
        poke(32'h3000, 8'h11); poke(32'h3001, 8'h22); poke(32'h3002, 8'h33); poke(32'h3003, 8'h44);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3000; mem_width = 2'b10;
        mem_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("rst_c1_ram_wr", 32'(ram_wr), 1);
        check_eq("rst_c1_ram_dout", 32'(ram_dout), 32'h0D);
        ref_mem[32'h3000] = 8'h0D;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_c2");
        rst = 1'b0; mem_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_no_wr", 32'(ram_wr), 0);
            check_eq("rst_busy", 32'(busy), 0);
        end
        for (int unsigned k = 0; k < 4; k++)
            check_eq("rst_ram_bytes", 32'(ram_rd(32'h3000 + k)), 32'(ref_rd(32'h3000 + k)));
        mem_run(1'b0, 32'h3000, 2'b11, 32'h0);

        // Address wrap past the top of the space.
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        mem_run(1'b0, 32'hFFFF_FFFE, 2'b10, 32'h0);
        mem_run(1'b1, 32'hFFFF_FFFF, 2'b01, 32'h0000_7766);
        if_run(32'hFFFF_FFFC, 0);

        for (int unsigned i = 0; i < 64; i++) poke(32'h6000 + i, 8'($urandom));
        for (int unsigned i = 0; i < 40; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = 32'h6000 + $urandom_range(0, 59);
            if (kind == 0)
                if_run(a & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
            else
                mem_run(kind == 2, a, 2'($urandom_range(0, 3)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
